// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - three-layer sequencer for the 2-neuron MLP datapath
module mlp_layer_sequencer #(
   parameter int INP_AW = 14,
   parameter int REG_AW = 10,
   parameter int DW     = 16,
   parameter int MAX_IN = 784
) (
   input  logic              pi_clk,
   input  logic              pi_rst,
   input  logic              pi_start,
   input  logic [9:0]        pi_n_in,
   input  logic [9:0]        pi_n_h1,
   input  logic [9:0]        pi_n_h2,
   input  logic [9:0]        pi_n_out,
   input  logic [DW-1:0]     pi_doa_reg,
   output logic              po_busy,
   output logic              po_done,
   output logic              po_err,
   output logic              po_valid,
   output logic              po_clc_accumulator,
   output logic              po_accumulation_done,
   output logic              po_en_inp,
   output logic              po_we_inp,
   output logic [INP_AW-1:0] po_addra_inp,
   output logic [INP_AW-1:0] po_addrb_inp,
   output logic [DW-1:0]     po_di_inp,
   output logic              po_en_wei,
   output logic [INP_AW-1:0] po_addra_wei,
   output logic [INP_AW-1:0] po_addrb_wei,
   output logic              po_en_reg,
   output logic              po_we_reg,
   output logic [REG_AW-1:0] po_addra_reg,
   output logic [REG_AW-1:0] po_addrb_reg
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_CLR   = 4'd1;
   localparam logic [3:0] S_RD    = 4'd2;
   localparam logic [3:0] S_VAL   = 4'd3;
   localparam logic [3:0] S_ACC1  = 4'd4;
   localparam logic [3:0] S_ACC2  = 4'd5;
   localparam logic [3:0] S_WR    = 4'd6;
   localparam logic [3:0] S_CP_RD = 4'd7;
   localparam logic [3:0] S_CP_W1 = 4'd8;
   localparam logic [3:0] S_CP_W2 = 4'd9;
   localparam logic [3:0] S_CP_WR = 4'd10;
   localparam logic [3:0] S_DONE  = 4'd11;

   localparam logic [9:0] MAX_IN_C = 10'(MAX_IN);

   logic [3:0]        state;
   logic [1:0]        layer;
   logic [9:0]        n_h2;
   logic [9:0]        n_out;
   logic [9:0]        pl;
   logic [9:0]        cl;
   logic [9:0]        j;
   logic [9:0]        k;
   logic [INP_AW-1:0] tot;
   logic [INP_AW-1:0] m;
   logic [INP_AW-1:0] n;
   logic [INP_AW-1:0] wbase;
   logic [INP_AW-1:0] cnt;
   logic [REG_AW-1:0] p;
   logic [DW-1:0]     cap;
   logic              err;

   logic              cfg_bad;
   logic [INP_AW-1:0] cfg_tot;
   logic [INP_AW-1:0] pl_x;
   logic [INP_AW-1:0] pl2_x;
   logic [INP_AW-1:0] cl_x;
   logic [INP_AW-1:0] k_x;
   logic              last_k;
   logic              last_j;
   logic              last_cnt;

   assign cfg_bad = (pi_n_in == 10'd0) || (pi_n_h1 == 10'd0) ||
                    (pi_n_h2 == 10'd0) || (pi_n_out == 10'd0) ||
                    pi_n_in[0] || pi_n_h1[0] || pi_n_h2[0] || pi_n_out[0] ||
                    (pi_n_in > MAX_IN_C);
   assign cfg_tot  = INP_AW'(pi_n_in) + INP_AW'(pi_n_h1) + INP_AW'(pi_n_h2) + INP_AW'(pi_n_out);
   assign pl_x     = INP_AW'(pl);
   assign pl2_x    = INP_AW'({pl, 1'b0});
   assign cl_x     = INP_AW'(cl);
   assign k_x      = INP_AW'(k);
   assign last_k   = (k == pl - 10'd1);
   assign last_j   = (j == (cl >> 1) - 10'd1);
   // n already points at the next layer's input base during the copy phase
   assign last_cnt = (cnt == n + cl_x - INP_AW'(1));

   assign po_busy = (state != S_IDLE);
   assign po_done = (state == S_DONE);
   assign po_err  = err;

   // Layer / neuron-pair / copy sequencing; wbase tracks M + 2*PL*j incrementally
   always_ff @(posedge pi_clk or posedge pi_rst) begin
      if (pi_rst) begin
         state <= S_IDLE;
         layer <= 2'd0;
         n_h2  <= 10'd0;
         n_out <= 10'd0;
         pl    <= 10'd0;
         cl    <= 10'd0;
         j     <= 10'd0;
         k     <= 10'd0;
         tot   <= '0;
         m     <= '0;
         n     <= '0;
         wbase <= '0;
         cnt   <= '0;
         p     <= '0;
         cap   <= '0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pi_start) begin
                  if (cfg_bad) begin
                     err <= 1'b1;
                  end else begin
                     n_h2  <= pi_n_h2;
                     n_out <= pi_n_out;
                     tot   <= cfg_tot;
                     layer <= 2'd0;
                     pl    <= pi_n_in;
                     cl    <= pi_n_h1;
                     m     <= '0;
                     n     <= '0;
                     wbase <= '0;
                     p     <= REG_AW'(pi_n_in);
                     j     <= 10'd0;
                     k     <= 10'd0;
                     state <= S_CLR;
                  end
               end
            end
            S_CLR: begin
               k     <= 10'd0;
               state <= S_RD;
            end
            S_RD: state <= S_VAL;
            S_VAL: begin
               if (last_k) begin
                  state <= S_ACC1;
               end else begin
                  k     <= k + 10'd1;
                  state <= S_RD;
               end
            end
            S_ACC1: state <= S_ACC2;
            S_ACC2: state <= S_WR;
            S_WR: begin
               p <= p + REG_AW'(2);
               if (last_j) begin
                  m     <= wbase + pl2_x;
                  n     <= n + pl_x;
                  cnt   <= n + pl_x;
                  state <= S_CP_RD;
               end else begin
                  j     <= j + 10'd1;
                  wbase <= wbase + pl2_x;
                  state <= S_CLR;
               end
            end
            S_CP_RD: state <= S_CP_W1;
            S_CP_W1: state <= S_CP_W2;
            S_CP_W2: begin
               cap   <= pi_doa_reg;
               state <= S_CP_WR;
            end
            S_CP_WR: begin
               if (!last_cnt) begin
                  cnt   <= cnt + INP_AW'(1);
                  state <= S_CP_RD;
               end else if (layer == 2'd2) begin
                  state <= S_DONE;
               end else begin
                  layer <= layer + 2'd1;
                  pl    <= cl;
                  cl    <= (layer == 2'd0) ? n_h2 : n_out;
                  j     <= 10'd0;
                  k     <= 10'd0;
                  wbase <= m;
                  state <= S_CLR;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobe and address decode; everything is zero outside the states that drive it
   always_comb begin
      po_valid             = 1'b0;
      po_clc_accumulator   = 1'b0;
      po_accumulation_done = 1'b0;
      po_en_inp            = 1'b0;
      po_we_inp            = 1'b0;
      po_addra_inp         = '0;
      po_addrb_inp         = '0;
      po_di_inp            = '0;
      po_en_wei            = 1'b0;
      po_addra_wei         = '0;
      po_addrb_wei         = '0;
      po_en_reg            = 1'b0;
      po_we_reg            = 1'b0;
      po_addra_reg         = '0;
      po_addrb_reg         = '0;
      case (state)
         S_CLR: po_clc_accumulator = 1'b1;
         S_RD, S_VAL: begin
            po_en_inp    = (state == S_RD);
            po_en_wei    = (state == S_RD);
            po_valid     = (state == S_VAL);
            po_addra_inp = n + k_x;
            po_addrb_inp = n + k_x;
            po_addra_wei = wbase + k_x;
            po_addrb_wei = wbase + pl_x + k_x;
         end
         S_ACC1, S_ACC2: po_accumulation_done = 1'b1;
         S_WR: begin
            po_en_reg    = 1'b1;
            po_we_reg    = 1'b1;
            po_addra_reg = p;
            po_addrb_reg = p + REG_AW'(1);
         end
         S_CP_RD, S_CP_W1, S_CP_W2: begin
            po_en_reg    = 1'b1;
            po_addra_reg = REG_AW'(cnt);
            po_addrb_reg = REG_AW'(cnt);
         end
         S_CP_WR: begin
            po_en_inp    = 1'b1;
            po_we_inp    = 1'b1;
            po_addra_inp = cnt;
            po_addrb_inp = cnt + tot;
            po_di_inp    = cap;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - scoreboard bench for mlp_layer_sequencer with BRAM/neuron models
module tb_mlp_layer_sequencer;
   localparam int INP_AW = 14;
   localparam int REG_AW = 10;
   localparam int DW     = 16;
   localparam int IM     = (1 << INP_AW) - 1;
   localparam int RM     = (1 << REG_AW) - 1;

   typedef struct {
      int a;
      int b;
      int c;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [9:0] n_in, n_h1, n_h2, n_out;
   logic [DW-1:0] doa_reg;
   logic busy, done, err, valid, clc, acc_done;
   logic en_inp, we_inp, en_wei, en_reg, we_reg;
   logic [INP_AW-1:0] addra_inp, addrb_inp, addra_wei, addrb_wei;
   logic [DW-1:0] di_inp;
   logic [REG_AW-1:0] addra_reg, addrb_reg;

   logic [DW-1:0] inp_mem [0:(1<<INP_AW)-1];
   logic [DW-1:0] wei_mem [0:(1<<INP_AW)-1];
   logic [DW-1:0] reg_mem [0:(1<<REG_AW)-1];
   logic [DW-1:0] rd_s1;
   int acc0, acc1;

   ev_t val_q[$], rw_q[$], cw_q[$], done_q[$];
   int  err_q[$];
   int  fin[$];
   int  fin_base, fin_tot;

   int n_chk = 0, n_fail = 0, n_done = 0;
   int busy_cyc = 0, acc_cyc = 0, val_cyc = 0;

   always #5 clk = ~clk;

   mlp_layer_sequencer dut (
      .pi_clk(clk), .pi_rst(rst), .pi_start(start),
      .pi_n_in(n_in), .pi_n_h1(n_h1), .pi_n_h2(n_h2), .pi_n_out(n_out),
      .pi_doa_reg(doa_reg),
      .po_busy(busy), .po_done(done), .po_err(err),
      .po_valid(valid), .po_clc_accumulator(clc), .po_accumulation_done(acc_done),
      .po_en_inp(en_inp), .po_we_inp(we_inp),
      .po_addra_inp(addra_inp), .po_addrb_inp(addrb_inp), .po_di_inp(di_inp),
      .po_en_wei(en_wei), .po_addra_wei(addra_wei), .po_addrb_wei(addrb_wei),
      .po_en_reg(en_reg), .po_we_reg(we_reg),
      .po_addra_reg(addra_reg), .po_addrb_reg(addrb_reg)
   );

   function automatic logic [15:0] act(input int x);
      if (x < 0) return 16'd0;
      if (x > 32767) return 16'h7FFF;
      return x[15:0];
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // BRAMs plus a two-neuron datapath; register BRAM has 2-cycle read latency
   always @(posedge clk) begin
      if (en_inp && we_inp) begin
         inp_mem[addra_inp] <= di_inp;
         inp_mem[addrb_inp] <= di_inp;
      end
      if (en_reg) begin
         if (we_reg) begin
            reg_mem[addra_reg] <= act(acc0);
            reg_mem[addrb_reg] <= act(acc1);
         end
         rd_s1   <= reg_mem[addra_reg];
         doa_reg <= rd_s1;
      end
      if (clc) begin
         acc0 = 0;
         acc1 = 0;
      end
      if (valid) begin
         acc0 = acc0 + int'($signed(inp_mem[addra_inp])) * int'($signed(wei_mem[addra_wei]));
         acc1 = acc1 + int'($signed(inp_mem[addrb_inp])) * int'($signed(wei_mem[addrb_wei]));
      end
   end

   // Monitor: pops expected events whenever the DUT presents one
   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         busy_cyc = 0;
         acc_cyc  = 0;
         val_cyc  = 0;
      end else begin
         if (busy && !done) busy_cyc++;
         if (acc_done) acc_cyc++;
         if (valid) val_cyc++;
         if (valid || clc || acc_done)
            chk("strobe_exclusive", int'(valid) + int'(clc) + int'(acc_done), 1);
         if (valid) begin
            if (val_q.size() == 0) chk("valid_unexpected", 1, 0);
            else begin
               e = val_q.pop_front();
               chk("addra_inp", int'(addra_inp), e.a & IM);
               chk("addrb_inp", int'(addrb_inp), e.a & IM);
               chk("addra_wei", int'(addra_wei), e.b & IM);
               chk("addrb_wei", int'(addrb_wei), e.c & IM);
            end
         end
         if (en_reg && we_reg) begin
            if (rw_q.size() == 0) chk("regwr_unexpected", 1, 0);
            else begin
               e = rw_q.pop_front();
               chk("addra_reg", int'(addra_reg), e.a & RM);
               chk("addrb_reg", int'(addrb_reg), e.b & RM);
            end
         end
         if (en_inp && we_inp) begin
            if (cw_q.size() == 0) chk("copy_unexpected", 1, 0);
            else begin
               e = cw_q.pop_front();
               chk("copy_addra", int'(addra_inp), e.a & IM);
               chk("copy_addrb", int'(addrb_inp), e.b & IM);
               chk("copy_data", int'(di_inp), e.c);
            end
         end
         if (err) begin
            if (err_q.size() == 0) chk("err_unexpected", 1, 0);
            else begin
               void'(err_q.pop_front());
               chk("err_busy", int'(busy), 0);
            end
         end
         if (done) begin
            n_done++;
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e = done_q.pop_front();
               chk("run_cycles", busy_cyc, e.a);
               chk("acc_done_cycles", acc_cyc, e.b);
               chk("valid_pulses", val_cyc, e.c);
               chk("pending_valid", val_q.size(), 0);
               chk("pending_copy", cw_q.size(), 0);
            end
            busy_cyc = 0;
            acc_cyc  = 0;
            val_cyc  = 0;
         end
      end
   end

   // Reference model: plain MLP arithmetic plus the address/timing rules, then a start pulse
   task automatic launch(input int ni, input int h1, input int h2, input int no, input bit ok);
      int cnt[4];
      int vec[$];
      int nxt[$];
      int wb, nb, pb, tot, cyc, accs, vals, s, pl, cl;
      ev_t e;
      cnt[0] = ni; cnt[1] = h1; cnt[2] = h2; cnt[3] = no;
      if (!ok) err_q.push_back(1);
      else begin
         tot = ni + h1 + h2 + no;
         wb = 0; nb = 0; pb = ni; cyc = 0; accs = 0; vals = 0;
         vec.delete();
         for (int i = 0; i < ni; i++) vec.push_back(int'($signed(inp_mem[i])));
         for (int l = 0; l < 3; l++) begin
            pl = cnt[l];
            cl = cnt[l+1];
            nxt.delete();
            for (int q = 0; q < cl; q++) begin
               s = 0;
               for (int i = 0; i < pl; i++)
                  s += vec[i] * int'($signed(wei_mem[(wb + pl*q + i) & IM]));
               nxt.push_back(int'(act(s)));
            end
            for (int jj = 0; jj < cl/2; jj++) begin
               for (int i = 0; i < pl; i++) begin
                  e.a = nb + i;
                  e.b = wb + 2*pl*jj + i;
                  e.c = e.b + pl;
                  val_q.push_back(e);
               end
               e.a = pb + 2*jj;
               e.b = pb + 2*jj + 1;
               e.c = 0;
               rw_q.push_back(e);
            end
            pb += cl;
            nb += pl;
            wb += pl*cl;
            for (int q = 0; q < cl; q++) begin
               e.a = nb + q;
               e.b = nb + q + tot;
               e.c = nxt[q];
               cw_q.push_back(e);
            end
            cyc  += (cl/2)*(1 + 2*pl + 3) + 4*cl;
            accs += cl;
            vals += (cl/2)*pl;
            vec = nxt;
         end
         e.a = cyc; e.b = accs; e.c = vals;
         done_q.push_back(e);
         fin = vec;
         fin_base = nb;
         fin_tot = tot;
      end
      @(posedge clk); #1;
      n_in = 10'(ni); n_h1 = 10'(h1); n_h2 = 10'(h2); n_out = 10'(no);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int target;
      int c;
      target = n_done + 1;
      c = 0;
      while (n_done < target && c < limit) begin
         @(posedge clk);
         c++;
      end
      if (n_done < target) chk("done_timeout", 0, 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_all_zero(input string name);
      chk(name, int'(|{busy, done, err, valid, clc, acc_done, en_inp, we_inp, addra_inp,
                       addrb_inp, di_inp, en_wei, addra_wei, addrb_wei, en_reg, we_reg,
                       addra_reg, addrb_reg}), 0);
   endtask

   initial begin
      int c;
      for (int i = 0; i < (1 << INP_AW); i++) begin
         inp_mem[i] = 16'($urandom_range(0, 15));
         wei_mem[i] = 16'(int'($urandom_range(0, 6)) - 3);
      end
      for (int i = 0; i < (1 << REG_AW); i++) reg_mem[i] = '0;
      rst = 1'b1; start = 1'b0;
      n_in = '0; n_h1 = '0; n_h2 = '0; n_out = '0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset_outputs");
      rst = 1'b0;

      // 4/2/2/2 baseline run
      launch(4, 2, 2, 2, 1'b1);
      wait_done(500);

      // illegal configurations
      launch(4, 3, 2, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bad_odd_idle", int'(busy | en_inp | en_wei | en_reg | we_inp | we_reg), 0);
         @(posedge clk); #1;
      end
      launch(800, 2, 2, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bad_max_idle", int'(busy | en_inp | en_wei | en_reg | we_inp | we_reg), 0);
         @(posedge clk); #1;
      end
      launch(4, 2, 2, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bad_zero_idle", int'(busy | en_inp | en_wei | en_reg | we_inp | we_reg), 0);
         @(posedge clk); #1;
      end
      chk("err_pulses_seen", err_q.size(), 0);

      // start pulsed mid-run is ignored
      launch(6, 4, 4, 2, 1'b1);
      repeat (30) @(posedge clk);
      #1 n_in = 10'd2; n_h1 = 10'd2; n_h2 = 10'd2; n_out = 10'd2; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(2000);

      // reset during a copy write aborts, then a clean rerun
      launch(4, 2, 2, 2, 1'b1);
      c = 0;
      while (!(en_inp && we_inp) && c < 500) begin
         @(negedge clk);
         c++;
      end
      chk("reach_cp_wr", int'(en_inp && we_inp), 1);
      #1 rst = 1'b1;
      #1 check_all_zero("abort_outputs");
      val_q.delete(); rw_q.delete(); cw_q.delete(); done_q.delete();
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      launch(4, 2, 2, 2, 1'b1);
      wait_done(500);

      // randomized legal configurations
      for (int r = 0; r < 4; r++) begin
         launch(2 * int'($urandom_range(1, 6)), 2 * int'($urandom_range(1, 6)),
                2 * int'($urandom_range(1, 6)), 2 * int'($urandom_range(1, 6)), 1'b1);
         wait_done(5000);
      end

      // full-size network
      launch(784, 16, 16, 10, 1'b1);
      wait_done(20000);
      for (int i = 0; i < fin.size(); i++) begin
         chk("final_inp_a", int'(inp_mem[fin_base + i]), fin[i]);
         chk("final_inp_b", int'(inp_mem[fin_base + i + fin_tot]), fin[i]);
      end

      chk("left_valid", val_q.size(), 0);
      chk("left_regwr", rw_q.size(), 0);
      chk("left_copy", cw_q.size(), 0);
      chk("left_done", done_q.size(), 0);
      chk("left_err", err_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
